// File: rtl/parking_occupancy_tracker.sv
// Occupancy tracker: 2-flop sensor synchronisers, event detect, occupancy counter, per-lane gate FSMs.
// Optional build macro PARK_DEBOUNCE_EN: an event needs DEBOUNCE_CYCLES consecutive synchronised-high clocks.

module park_gate_fsm #(
   parameter int unsigned GATE_CYCLES = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic accept,
   output logic idle,
   output logic gate_open
);
   localparam int unsigned GW = $clog2(GATE_CYCLES + 1);
   localparam logic [GW-1:0] OPEN_LAST = GW'(GATE_CYCLES - 1);

   typedef enum logic [1:0] {GATE_IDLE, GATE_OPEN, GATE_CLOSE} gate_state_t;

   gate_state_t     state;
   logic [GW-1:0]   open_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= GATE_IDLE;
         open_cnt  <= '0;
         gate_open <= 1'b0;
      end else begin
         case (state)
            GATE_IDLE: begin
               if (accept) begin
                  state     <= GATE_OPEN;
                  open_cnt  <= '0;
                  gate_open <= 1'b1;
               end
            end
            GATE_OPEN: begin
               if (open_cnt == OPEN_LAST) begin
                  state     <= GATE_CLOSE;
                  gate_open <= 1'b0;
               end else begin
                  open_cnt <= open_cnt + 1'b1;
               end
            end
            GATE_CLOSE: state <= GATE_IDLE;
            default: begin
               state     <= GATE_IDLE;
               gate_open <= 1'b0;
            end
         endcase
      end
   end

   assign idle = (state == GATE_IDLE);
endmodule

module parking_occupancy_tracker #(
   parameter int unsigned CAPACITY        = 4,
   parameter int unsigned CNT_W           = 3,
   parameter int unsigned GATE_CYCLES     = 8,
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_sensor,
   input  logic             out_sensor,
   output logic [CNT_W-1:0] parked,
   output logic [CNT_W-1:0] empty_slots,
   output logic             lot_full,
   output logic             lot_empty,
   output logic             gate_in_open,
   output logic             gate_out_open,
   output logic             reject_in,
   output logic             err_underflow
);
   localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);

   if (CAPACITY < 1 || (2 ** CNT_W) <= CAPACITY || GATE_CYCLES < 1 || DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
      $error("parking_occupancy_tracker: illegal parameter set");
   end

   // Lane bit 0 is entry, bit 1 is exit.
   logic [1:0] sens_s1, sens_s2, sens_evt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sens_s1 <= '0;
         sens_s2 <= '0;
      end else begin
         sens_s1 <= {out_sensor, in_sensor};
         sens_s2 <= sens_s1;
      end
   end

`ifdef PARK_DEBOUNCE_EN
   localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [DB_W-1:0] DB_HELD = DB_W'(DEBOUNCE_CYCLES);

   logic [DB_W-1:0] high_cnt [2];

   // high_cnt saturates one past the firing value, so a held sensor fires once; any low clock re-arms.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sens_evt <= '0;
         for (int unsigned i = 0; i < 2; i++) high_cnt[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < 2; i++) begin
            sens_evt[i] <= sens_s2[i] && (high_cnt[i] == DB_LAST);
            if (!sens_s2[i])
               high_cnt[i] <= '0;
            else if (high_cnt[i] != DB_HELD)
               high_cnt[i] <= high_cnt[i] + 1'b1;
         end
      end
   end
`else
   logic [1:0] sens_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sens_d   <= '0;
         sens_evt <= '0;
      end else begin
         sens_d   <= sens_s2;
         sens_evt <= sens_s2 & ~sens_d;
      end
   end
`endif

   logic in_evt, out_evt, in_idle, out_idle, in_acc, out_acc;
   logic [CNT_W-1:0] parked_nxt;

   assign in_evt  = sens_evt[0];
   assign out_evt = sens_evt[1];

   // A same-cycle accepted exit frees the slot the entry needs, so a full lot can still admit.
   always_comb begin
      out_acc    = out_evt && out_idle && (parked != '0);
      in_acc     = in_evt && in_idle && ((parked < CAP) || out_acc);
      parked_nxt = parked;
      if (in_acc && !out_acc)
         parked_nxt = parked + 1'b1;
      else if (out_acc && !in_acc)
         parked_nxt = parked - 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         parked        <= '0;
         empty_slots   <= CAP;
         lot_full      <= 1'b0;
         lot_empty     <= 1'b1;
         reject_in     <= 1'b0;
         err_underflow <= 1'b0;
      end else begin
         parked        <= parked_nxt;
         empty_slots   <= CAP - parked_nxt;
         lot_full      <= (parked_nxt == CAP);
         lot_empty     <= (parked_nxt == '0);
         reject_in     <= in_evt && !in_acc;
         err_underflow <= out_evt && (parked == '0);
      end
   end

   park_gate_fsm #(.GATE_CYCLES(GATE_CYCLES)) u_gate_in (
      .clk       (clk),
      .rst_n     (rst_n),
      .accept    (in_acc),
      .idle      (in_idle),
      .gate_open (gate_in_open)
   );

   park_gate_fsm #(.GATE_CYCLES(GATE_CYCLES)) u_gate_out (
      .clk       (clk),
      .rst_n     (rst_n),
      .accept    (out_acc),
      .idle      (out_idle),
      .gate_open (gate_out_open)
   );
endmodule

// File: tb/tb_parking_occupancy_tracker.sv
// Self-checking bench for parking_occupancy_tracker: directed scenarios plus random sensor traffic
// against an event/time-based occupancy model. Honours PARK_DEBOUNCE_EN like the design.

module tb_parking_occupancy_tracker;
   localparam int CAP = 4;
   localparam int CW  = 3;
   localparam int GC  = 8;
   localparam int DB  = 4;
`ifdef PARK_DEBOUNCE_EN
   localparam int D_EFF = DB;
`else
   localparam int D_EFF = 1;
`endif
   localparam int HOLD = 4;
   localparam int GAP  = GC + 8;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic in_sensor = 1'b0;
   logic out_sensor = 1'b0;
   logic [CW-1:0] parked, empty_slots;
   logic lot_full, lot_empty, gate_in_open, gate_out_open, reject_in, err_underflow;

   parking_occupancy_tracker #(
      .CAPACITY        (CAP),
      .CNT_W           (CW),
      .GATE_CYCLES     (GC),
      .DEBOUNCE_CYCLES (DB)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_sensor     (in_sensor),
      .out_sensor    (out_sensor),
      .parked        (parked),
      .empty_slots   (empty_slots),
      .lot_full      (lot_full),
      .lot_empty     (lot_empty),
      .gate_in_open  (gate_in_open),
      .gate_out_open (gate_out_open),
      .reject_in     (reject_in),
      .err_underflow (err_underflow)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass = 0;

   task automatic check_val(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
   endtask

   // Model: a sensor sample at edge k ends a high run; a run reaching D_EFF is one event,
   // acted on at edge k+3. A gate accepted at edge a is open after edges a..a+GC-1, idle from a+GC+2.
   int m_parked, edge_n, in_last, out_last, in_run, out_run;
   bit m_rej, m_unf;
   bit in_q[$];
   bit out_q[$];
   int obs_rej, obs_unf, obs_gin, obs_gout;

   task automatic model_reset();
      m_parked = 0;
      in_last  = -1000;
      out_last = -1000;
      in_run   = 0;
      out_run  = 0;
      m_rej    = 1'b0;
      m_unf    = 1'b0;
      in_q     = '{1'b0, 1'b0, 1'b0};
      out_q    = '{1'b0, 1'b0, 1'b0};
   endtask

   task automatic model_step();
      bit ie, oe, in_idle, out_idle, in_acc, out_acc;
      edge_n++;
      ie = in_q.pop_front();
      oe = out_q.pop_front();
      in_idle  = edge_n >= in_last + GC + 2;
      out_idle = edge_n >= out_last + GC + 2;
      out_acc  = oe && out_idle && (m_parked > 0);
      in_acc   = ie && in_idle && ((m_parked < CAP) || out_acc);
      m_rej    = ie && !in_acc;
      m_unf    = oe && (m_parked == 0);
      m_parked = m_parked + int'(in_acc) - int'(out_acc);
      if (in_acc) in_last = edge_n;
      if (out_acc) out_last = edge_n;
      in_run  = in_sensor ? in_run + 1 : 0;
      out_run = out_sensor ? out_run + 1 : 0;
      in_q.push_back(in_run == D_EFF);
      out_q.push_back(out_run == D_EFF);
   endtask

   task automatic compare_all();
      bit exp_gin, exp_gout;
      exp_gin  = (edge_n >= in_last) && (edge_n < in_last + GC);
      exp_gout = (edge_n >= out_last) && (edge_n < out_last + GC);
      check_val("parked", int'(parked), m_parked);
      check_val("empty_slots", int'(empty_slots), CAP - m_parked);
      check_val("lot_full", int'(lot_full), int'(m_parked == CAP));
      check_val("lot_empty", int'(lot_empty), int'(m_parked == 0));
      check_val("gate_in_open", int'(gate_in_open), int'(exp_gin));
      check_val("gate_out_open", int'(gate_out_open), int'(exp_gout));
      check_val("reject_in", int'(reject_in), int'(m_rej));
      check_val("err_underflow", int'(err_underflow), int'(m_unf));
      obs_rej  += int'(reject_in);
      obs_unf  += int'(err_underflow);
      obs_gin  += int'(gate_in_open);
      obs_gout += int'(gate_out_open);
   endtask

   task automatic clear_stats();
      obs_rej = 0; obs_unf = 0; obs_gin = 0; obs_gout = 0;
   endtask

   task automatic cycle();
      @(posedge clk);
      if (rst_n) model_step();
      @(negedge clk);
      compare_all();
   endtask

   task automatic drive(input bit i, input bit o, input int n);
      in_sensor  = i;
      out_sensor = o;
      repeat (n) cycle();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bit seen;
      int in_hold, out_hold;
      edge_n = 0;
      model_reset();
      clear_stats();
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      compare_all();
      rst_n = 1'b1;

      // Exit with an empty lot
      clear_stats();
      drive(0, 1, HOLD); drive(0, 0, GAP);
      check_val("t2_underflow_pulses", obs_unf, 1);
      check_val("t2_parked", int'(parked), 0);
      check_val("t2_lot_empty", int'(lot_empty), 1);

      // Fill the lot, then one more
      for (int k = 0; k < CAP; k++) begin
         drive(1, 0, HOLD); drive(0, 0, GAP);
      end
      check_val("t1_parked_full", int'(parked), CAP);
      check_val("t1_empty_zero", int'(empty_slots), 0);
      check_val("t1_lot_full", int'(lot_full), 1);
      clear_stats();
      drive(1, 0, HOLD); drive(0, 0, GAP);
      check_val("t1_reject_pulses", obs_rej, 1);
      check_val("t1_gate_in_cycles", obs_gin, 0);
      check_val("t1_parked_held", int'(parked), CAP);

      // Simultaneous entry and exit on a full lot
      clear_stats();
      drive(1, 1, HOLD); drive(0, 0, GAP);
      check_val("t3_gate_in_cycles", obs_gin, GC);
      check_val("t3_gate_out_cycles", obs_gout, GC);
      check_val("t3_reject_pulses", obs_rej, 0);
      check_val("t3_parked", int'(parked), CAP);

      // Second entry while the entry gate is open
      drive(0, 1, HOLD); drive(0, 0, GAP);
      check_val("t4_parked_before", int'(parked), CAP - 1);
      clear_stats();
      drive(1, 0, D_EFF); drive(0, 0, 2); drive(1, 0, D_EFF); drive(0, 0, GAP);
      check_val("t4_reject_pulses", obs_rej, 1);
      check_val("t4_parked_once", int'(parked), CAP);

      // Asynchronous reset while the entry gate is open
      for (int k = 0; k < CAP; k++) begin
         drive(0, 1, HOLD); drive(0, 0, GAP);
      end
      check_val("t5_drained", int'(parked), 0);
      for (int k = 0; k < 2; k++) begin
         drive(1, 0, HOLD); drive(0, 0, GAP);
      end
      drive(1, 0, HOLD);
      in_sensor = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         cycle();
         seen = gate_in_open;
      end
      check_val("t5_gate_open_seen", int'(seen), 1);
      check_val("t5_parked_three", int'(parked), 3);
      @(posedge clk);
      model_step();
      #2 rst_n = 1'b0;
      #1 model_reset();
      compare_all();
      check_val("t5_reset_parked", int'(parked), 0);
      check_val("t5_reset_empty", int'(empty_slots), CAP);
      check_val("t5_reset_gate_in", int'(gate_in_open), 0);
      @(negedge clk);
      repeat (2) cycle();
      rst_n = 1'b1;
      drive(1, 0, HOLD); drive(0, 0, GAP);
      check_val("t5_parked_after", int'(parked), 1);

      // Two-clock glitch on the entry sensor
      drive(1, 0, 2); drive(0, 0, GAP);
`ifdef PARK_DEBOUNCE_EN
      check_val("t6_glitch_parked", int'(parked), 1);
`else
      check_val("t6_glitch_parked", int'(parked), 2);
`endif

      // Random sensor traffic
      in_hold = 0;
      out_hold = 0;
      repeat (3000) begin
         if (in_hold == 0) begin
            in_sensor = ~in_sensor;
            in_hold = $urandom_range(1, 10);
         end
         if (out_hold == 0) begin
            out_sensor = ~out_sensor;
            out_hold = $urandom_range(1, 10);
         end
         in_hold--;
         out_hold--;
         cycle();
      end
      drive(0, 0, GAP);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
